// File: rtl/dram_wr_pkg.sv
// Shared types and constants for the DQ byte-group write scheduler.
package dram_wr_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StPre,
    StData,
    StPost
  } wr_state_e;

  // Burst length expressed in core clocks (two DDR beats per clock).
  localparam int unsigned BEATS_BL4 = 2;
  localparam int unsigned BEATS_BL8 = 4;

  localparam int unsigned ERR_UNDERRUN = 0;
  localparam int unsigned ERR_BUSY     = 1;

endpackage

// File: rtl/dram_dq_wr_sched_if.sv
// Command and write-data handshake between the write buffer and the DQ scheduler.
interface dram_dq_wr_sched_if #(
  parameter int unsigned DQ_W  = 16,
  parameter int unsigned LAT_W = 2
);
  logic               wr_start;
  logic               wr_bl4;
  logic [LAT_W-1:0]   wr_lat;
  logic               wr_data_vld;
  logic [2*DQ_W-1:0]  wr_data;
  logic               wr_data_rdy;

  modport master (
    output wr_start, wr_bl4, wr_lat, wr_data_vld, wr_data,
    input  wr_data_rdy
  );

  modport slave (
    input  wr_start, wr_bl4, wr_lat, wr_data_vld, wr_data,
    output wr_data_rdy
  );
endinterface

// File: rtl/dram_dq_wr_sched.sv
// Write-side scheduler for one DQ byte-group: latency wait, preamble, data burst, postamble.
module dram_dq_wr_sched
  import dram_wr_pkg::*;
#(
  parameter int unsigned DQ_W  = 16,
  parameter int unsigned LAT_W = 2
) (
  input  logic              rclk,
  input  logic              rst_l,
  dram_dq_wr_sched_if.slave wr_bus,
  input  logic              dram_io_channel_disabled,
  input  logic              err_clr,
  output logic [DQ_W-1:0]   data_pos,
  output logic [DQ_W-1:0]   data_neg,
  output logic              dram_io_drive_enable,
  output logic              dram_io_pad_enable,
  output logic              wr_busy,
  output logic              wr_done,
  output logic [1:0]        err
);

  // One down-counter serves both the latency wait and the beat count.
  localparam int unsigned CntW = (LAT_W > 2) ? LAT_W : 2;

  wr_state_e         state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              bl4_q, bl4_d;
  logic [2*DQ_W-1:0] dq_q, dq_d;
  logic [1:0]        err_q, err_d;
  logic              pad_en_q;
  logic              rdy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bl4_d   = bl4_q;
    rdy     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (wr_bus.wr_start && !dram_io_channel_disabled) begin
          bl4_d = wr_bus.wr_bl4;
          if (wr_bus.wr_lat != '0) begin
            state_d = StWait;
            cnt_d   = CntW'(wr_bus.wr_lat - 1'b1);
          end else begin
            state_d = StPre;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) state_d = StPre;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StPre: begin
        rdy     = 1'b1;
        state_d = StData;
        cnt_d   = bl4_q ? CntW'(BEATS_BL4 - 1) : CntW'(BEATS_BL8 - 1);
      end
      StData: begin
        // Last beat takes no word: the capture in PRE already filled the pipe.
        if (cnt_q == '0) begin
          state_d = StPost;
        end else begin
          rdy   = 1'b1;
          cnt_d = cnt_q - 1'b1;
        end
      end
      StPost:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    dq_d  = (rdy && wr_bus.wr_data_vld) ? wr_bus.wr_data : '0;
    err_d = err_clr ? 2'b00 : err_q;
    if (rdy && !wr_bus.wr_data_vld)         err_d[ERR_UNDERRUN] = 1'b1;
    if (wr_bus.wr_start && state_q != StIdle) err_d[ERR_BUSY]   = 1'b1;
  end

  always_ff @(posedge rclk) begin
    pad_en_q <= ~dram_io_channel_disabled;
    if (!rst_l) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bl4_q   <= 1'b0;
      dq_q    <= '0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bl4_q   <= bl4_d;
      dq_q    <= dq_d;
      err_q   <= err_d;
    end
  end

  assign wr_bus.wr_data_rdy   = rdy;
  assign data_pos             = dq_q[DQ_W-1:0];
  assign data_neg             = dq_q[2*DQ_W-1:DQ_W];
  assign dram_io_drive_enable = state_q inside {StPre, StData, StPost};
  assign dram_io_pad_enable   = pad_en_q;
  assign wr_busy              = (state_q != StIdle);
  assign wr_done              = (state_q == StPost);
  assign err                  = err_q;

endmodule

// File: tb/tb_dram_dq_wr_sched.sv
// Bench for dram_dq_wr_sched: burst-timeline model plus directed literal checks and random traffic.
module tb_dram_dq_wr_sched;
  import dram_wr_pkg::*;

  localparam int unsigned DQ_W  = 16;
  localparam int unsigned LAT_W = 2;

  logic            rclk = 1'b0;
  logic            rst_l = 1'b0;
  logic            dis = 1'b0;
  logic            err_clr = 1'b0;
  logic [DQ_W-1:0] data_pos, data_neg;
  logic            drv, pad, busy, done;
  logic [1:0]      err;

  dram_dq_wr_sched_if #(.DQ_W(DQ_W), .LAT_W(LAT_W)) bus ();

  dram_dq_wr_sched #(.DQ_W(DQ_W), .LAT_W(LAT_W)) dut (
    .rclk                     (rclk),
    .rst_l                    (rst_l),
    .wr_bus                   (bus),
    .dram_io_channel_disabled (dis),
    .err_clr                  (err_clr),
    .data_pos                 (data_pos),
    .data_neg                 (data_neg),
    .dram_io_drive_enable     (drv),
    .dram_io_pad_enable       (pad),
    .wr_busy                  (busy),
    .wr_done                  (done),
    .err                      (err)
  );

  always #5 rclk = ~rclk;

  int total = 0;
  int bad   = 0;

  // Model: one burst record {start cycle, latency, clocks}; outputs follow from the timeline.
  int              cyc   = 0;
  bit              m_act = 1'b0;
  int              bs    = 0;
  int              bl    = 0;
  int              bn    = 0;
  logic [2*DQ_W-1:0] m_dq  = '0;
  logic [1:0]      m_err = 2'b00;
  logic            m_pad = 1'b1;

  function automatic bit m_in(input int lo, input int hi);
    int r;
    r = cyc - bs;
    return m_act && (r >= lo) && (r <= hi);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  task automatic compare();
    #1;
    chk("busy", busy, m_act);
    chk("drive_en", drv, m_in(bl + 1, bl + 2 + bn));
    chk("done", done, m_in(bl + 2 + bn, bl + 2 + bn));
    chk("rdy", bus.wr_data_rdy, m_in(bl + 1, bl + bn));
    chk("data", {data_neg, data_pos}, m_dq);
    chk("err", err, m_err);
    chk("pad_en", pad, m_pad);
  endtask

  task automatic advance();
    bit         r;
    logic [1:0] e;
    r = m_in(bl + 1, bl + bn);
    if (!rst_l) begin
      m_act = 1'b0;
      m_dq  = '0;
      m_err = 2'b00;
    end else begin
      e = err_clr ? 2'b00 : m_err;
      if (r && !bus.wr_data_vld) e[ERR_UNDERRUN] = 1'b1;
      if (bus.wr_start && m_act) e[ERR_BUSY] = 1'b1;
      m_err = e;
      m_dq  = (r && bus.wr_data_vld) ? bus.wr_data : '0;
      if (m_act && (cyc - bs == bl + 2 + bn)) begin
        m_act = 1'b0;
      end else if (!m_act && bus.wr_start && !dis) begin
        m_act = 1'b1;
        bs    = cyc;
        bl    = int'(bus.wr_lat);
        bn    = bus.wr_bl4 ? BEATS_BL4 : BEATS_BL8;
      end
    end
    m_pad = ~dis;
    @(posedge rclk);
    cyc++;
    #1;
  endtask

  task automatic defaults();
    rst_l           = 1'b1;
    dis             = 1'b0;
    err_clr         = 1'b0;
    bus.wr_start    = 1'b0;
    bus.wr_bl4      = 1'b0;
    bus.wr_lat      = '0;
    bus.wr_data_vld = 1'b1;
    bus.wr_data     = (2*DQ_W)'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      defaults();
      compare();
      advance();
    end
  endtask

  logic [31:0] w [4];
  int          hs;
  int          idx;

  initial begin
    w[0] = 32'h1111_aaaa; w[1] = 32'h2222_bbbb; w[2] = 32'h3333_cccc; w[3] = 32'h4444_dddd;
    defaults();
    rst_l = 1'b0;
    advance();
    advance();
    rst_l = 1'b1;

    // Reset state.
    compare();
    chk("rst_busy", busy, 1'b0);
    chk("rst_drive", drv, 1'b0);
    chk("rst_data", {data_neg, data_pos}, 32'h0);
    chk("rst_err", err, 2'b00);
    chk("rst_pad", pad, 1'b1);
    advance();
    idle(2);

    // bl8, lat0, clean data.
    for (int k = 0; k <= 7; k++) begin
      defaults();
      bus.wr_start = (k == 0);
      if (k >= 1 && k <= 4) bus.wr_data = w[k-1];
      compare();
      chk("t1_drive", drv, (k >= 1 && k <= 6));
      chk("t1_done", done, (k == 6));
      chk("t1_busy", busy, (k >= 1 && k <= 6));
      if (k >= 2 && k <= 5) chk("t1_data", {data_neg, data_pos}, w[k-2]);
      advance();
    end
    chk("t1_err", err, 2'b00);
    idle(2);

    // bl4, lat3.
    hs = 0;
    for (int k = 0; k <= 8; k++) begin
      defaults();
      bus.wr_start = (k == 0);
      bus.wr_bl4   = 1'b1;
      bus.wr_lat   = 2'd3;
      if (k == 4) bus.wr_data = w[0];
      if (k == 5) bus.wr_data = w[1];
      compare();
      if (bus.wr_data_rdy && bus.wr_data_vld) hs++;
      chk("t2_drive", drv, (k >= 4 && k <= 7));
      chk("t2_done", done, (k == 7));
      if (k == 5) chk("t2_data0", {data_neg, data_pos}, w[0]);
      if (k == 6) chk("t2_data1", {data_neg, data_pos}, w[1]);
      advance();
    end
    chk("t2_handshakes", hs, 2);
    idle(2);

    // bl8, lat0, underrun on the second capture; buffer replays the missed word.
    idx = 0;
    for (int k = 0; k <= 7; k++) begin
      defaults();
      bus.wr_start    = (k == 0);
      bus.wr_data     = w[idx];
      bus.wr_data_vld = (k != 2);
      compare();
      if (bus.wr_data_rdy && bus.wr_data_vld && idx < 3) idx++;
      if (k == 2) chk("t3_data_w0", {data_neg, data_pos}, w[0]);
      if (k == 3) chk("t3_data_gap", {data_neg, data_pos}, 32'h0);
      if (k == 3) chk("t3_err", err, 2'b01);
      if (k == 4) chk("t3_data_w1", {data_neg, data_pos}, w[1]);
      if (k == 5) chk("t3_data_w2", {data_neg, data_pos}, w[2]);
      chk("t3_done", done, (k == 6));
      advance();
    end
    defaults();
    err_clr = 1'b1;
    compare();
    advance();
    idle(1);

    // Start while busy, then err_clr.
    for (int k = 0; k <= 11; k++) begin
      defaults();
      bus.wr_start = (k == 0 || k == 3);
      bus.wr_lat   = (k == 3) ? 2'd2 : 2'd0;
      err_clr      = (k == 10);
      compare();
      chk("t4_drive", drv, (k >= 1 && k <= 6));
      chk("t4_done", done, (k == 6));
      if (k >= 4 && k <= 10) chk("t4_err", err, 2'b10);
      if (k == 11) chk("t4_err_clr", err, 2'b00);
      advance();
    end
    idle(1);

    // Reset mid-burst, then a fresh burst.
    for (int k = 0; k <= 13; k++) begin
      defaults();
      rst_l        = (k != 3);
      bus.wr_start = (k == 0 || k == 5);
      compare();
      if (k == 4) begin
        chk("t5_busy", busy, 1'b0);
        chk("t5_drive", drv, 1'b0);
        chk("t5_data", {data_neg, data_pos}, 32'h0);
        chk("t5_err", err, 2'b00);
      end
      chk("t5_done", done, (k == 11));
      if (k >= 6 && k <= 11) chk("t5_drive2", drv, 1'b1);
      advance();
    end
    idle(1);

    // Channel disabled drops the start; pad enable follows one cycle late.
    for (int k = 0; k <= 4; k++) begin
      defaults();
      dis          = (k <= 2);
      bus.wr_start = (k == 1);
      compare();
      chk("t6_busy", busy, 1'b0);
      if (k == 1) chk("t6_pad_off", pad, 1'b0);
      if (k == 3) chk("t6_pad_still_off", pad, 1'b0);
      if (k == 4) chk("t6_pad_on", pad, 1'b1);
      advance();
    end

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_l           = ($urandom_range(0, 99) != 0);
      dis             = ($urandom_range(0, 19) == 0);
      err_clr         = ($urandom_range(0, 15) == 0);
      bus.wr_start    = ($urandom_range(0, 3) == 0);
      bus.wr_bl4      = 1'($urandom_range(0, 1));
      bus.wr_lat      = LAT_W'($urandom_range(0, 3));
      bus.wr_data_vld = ($urandom_range(0, 7) != 0);
      bus.wr_data     = (2*DQ_W)'($urandom);
      compare();
      advance();
    end
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
